noc_packet_arbiter: RTL and testbench

Packet-level round-robin arbiter that shares one NoC output channel, typically the input side of a `noc_buffer` or a router output port, between N requesting input channels. Arbitration happens on packet boundaries. Once a channel wins, it owns the output until the flit carrying `last` completes a handshake, so packets are never interleaved. Inputs and output both use the codebase's valid/ready flit handshake with a `last` sideband.

---
 rtl/noc_packet_arbiter_if.sv | 24 ++
 rtl/noc_packet_arbiter.sv | 93 +++++++++
 tb/tb_noc_packet_arbiter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/noc_packet_arbiter_if.sv
// noc_packet_arbiter_if: flit request channels, shared output channel and grant/busy status
interface noc_packet_arbiter_if #(
  parameter int FLIT_WIDTH = 32,
  parameter int NUM_IN     = 4
);
  logic [NUM_IN*FLIT_WIDTH-1:0] in_flit;
  logic [NUM_IN-1:0]            in_last;
  logic [NUM_IN-1:0]            in_valid;
  logic [NUM_IN-1:0]            in_ready;
  logic [FLIT_WIDTH-1:0]        out_flit;
  logic                         out_last;
  logic                         out_valid;
  logic                         out_ready;
  logic [NUM_IN-1:0]            grant;
  logic                         busy;
  modport slave (
    input  in_flit, in_last, in_valid, out_ready,
    output in_ready, out_flit, out_last, out_valid, grant, busy
  );
  modport master (
    output in_flit, in_last, in_valid, out_ready,
    input  in_ready, out_flit, out_last, out_valid, grant, busy
  );
endinterface

// File: rtl/noc_packet_arbiter.sv
// noc_packet_arbiter: packet-level round-robin arbiter; NOC_ARB_OUTREG_EN adds a 2-entry output skid register
module noc_packet_arbiter #(
  parameter int FLIT_WIDTH = 32,
  parameter int NUM_IN     = 4
) (
  input  logic                clk,
  input  logic                rst,
  noc_packet_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_IN);
  typedef enum logic {IDLE, LOCKED} state_e;
  state_e                state_q, state_d;
  logic [IW-1:0]         cur_q, cur_d, last_win_q, last_win_d, win, sel;
  logic                  any_v, active, up_valid, up_ready, up_last, up_hs_last;
  logic [FLIT_WIDTH-1:0] up_flit;
  // Descending scan so the channel closest after last_win is the final overwrite
  always_comb begin
    win = last_win_q;
    for (int k = NUM_IN; k >= 1; k--) begin
      int t;
      t = int'(last_win_q) + k;
      t = t >= NUM_IN ? t - NUM_IN : t;
      if (bus.in_valid[IW'(t)]) win = IW'(t);
    end
  end
  assign any_v      = |bus.in_valid;
  assign sel        = state_q == LOCKED ? cur_q : win;
  assign active     = !rst && (state_q == LOCKED || any_v);
  assign up_valid   = !rst && bus.in_valid[sel];
  assign up_flit    = bus.in_flit[sel*FLIT_WIDTH +: FLIT_WIDTH];
  assign up_last    = bus.in_last[sel];
  assign up_hs_last = up_valid && up_ready && up_last;
  assign bus.grant    = active ? NUM_IN'(1) << sel : '0;
  assign bus.in_ready = active ? NUM_IN'(up_ready) << sel : '0;
  assign bus.busy     = state_q == LOCKED;
  // A presented flit without a last handshake locks its source so out_* stay stable
  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    last_win_d = last_win_q;
    if (state_q == IDLE) begin
      if (any_v) begin
        last_win_d = win;
        if (!up_hs_last) begin
          state_d = LOCKED;
          cur_d   = win;
        end
      end
    end else if (up_hs_last) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cur_q      <= '0;
      last_win_q <= IW'(NUM_IN - 1);
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      last_win_q <= last_win_d;
    end
  end
`ifdef NOC_ARB_OUTREG_EN
  logic [FLIT_WIDTH:0] skid_q [2];
  logic                wr_q, rd_q, push, pop;
  logic [1:0]          cnt_q, cnt_d;
  assign up_ready = cnt_q != 2'd2;
  assign push     = up_valid && up_ready;
  assign pop      = bus.out_valid && bus.out_ready;
  assign cnt_d    = cnt_q + 2'(push) - 2'(pop);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_q ^ push;
      rd_q  <= rd_q ^ pop;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) skid_q[wr_q] <= {up_last, up_flit};
  end
  assign bus.out_valid                = cnt_q != '0;
  assign {bus.out_last, bus.out_flit} = bus.out_valid ? skid_q[rd_q] : '0;
`else
  assign up_ready                     = bus.out_ready;
  assign bus.out_valid                = up_valid;
  assign {bus.out_last, bus.out_flit} = up_valid ? {up_last, up_flit} : '0;
`endif
endmodule

// File: tb/tb_noc_packet_arbiter.sv
// tb_noc_packet_arbiter: vector table for selection/gating plus scoreboarded packet sequences
`timescale 1ns/1ps
module tb_noc_packet_arbiter;
  localparam int W = 32;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  noc_packet_arbiter_if #(.FLIT_WIDTH(W), .NUM_IN(N)) bus ();
  noc_packet_arbiter #(.FLIT_WIDTH(W), .NUM_IN(N)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    logic         r;
    logic [N-1:0] v;
    logic         o;
    logic [N-1:0] g;
    logic [N-1:0] rdy;
    logic         ov;
    int           ch;
  } vec_t;
  int          checks = 0;
  int          errors = 0;
  logic [W:0]  src [N][$];
  logic [W:0]  exp_q [$];
  logic [N-1:0] mask;
  logic        ordy;
  bit          rnd;
  int          cyc, first_hs, last_hs;
  task automatic chk(string name, logic [W:0] act, logic [W:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask
  task automatic drive();
    for (int i = 0; i < N; i++) begin
      logic [W:0] f;
      f = src[i].size() != 0 ? src[i][0] : '0;
      bus.in_valid[i]        = src[i].size() != 0 && !mask[i];
      bus.in_last[i]         = f[W];
      bus.in_flit[i*W +: W]  = f[W-1:0];
    end
    bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : ordy;
  endtask
  function automatic bit src_pending();
    for (int i = 0; i < N; i++) if (src[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction
  // Snapshot handshakes mid-cycle, retire them after the edge, then re-drive
  task automatic step();
    logic [N-1:0] hs;
    @(negedge clk);
    hs = bus.in_valid & bus.in_ready;
    if (bus.out_valid && bus.out_ready) begin
      if (first_hs < 0) first_hs = cyc;
      last_hs = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_extra: got %h want no output", {bus.out_last, bus.out_flit});
      end else begin
        chk("sb_flit", {bus.out_last, bus.out_flit}, exp_q.pop_front());
      end
    end
    cyc++;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (hs[i]) void'(src[i].pop_front());
    drive();
  endtask
  task automatic do_reset();
    rst  = 1'b1;
    mask = '0;
    ordy = 1'b1;
    rnd  = 1'b0;
    for (int i = 0; i < N; i++) src[i].delete();
    exp_q.delete();
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    drive();
    first_hs = -1;
    last_hs  = -1;
    cyc      = 0;
  endtask
  task automatic put(int ch, logic [W-1:0] d, logic l);
    src[ch].push_back({l, d});
    exp_q.push_back({l, d});
  endtask
  task automatic drain(string name, int bound);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || src_pending()) && n < bound) begin
      step();
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || src_pending()) begin
      errors++;
      $display("FAIL %s_timeout: got %0d flits outstanding want 0", name, exp_q.size());
    end
    repeat (3) step();
  endtask
  task automatic rr_load();
    for (int s = 0; s < 3; s++)
      for (int c = 0; c < N; c++) put(c, 32'h1000_0000 | (c << 8) | s, 1'b1);
    drive();
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1);
  end
  initial begin
    vec_t tv [7];
    tv[0] = '{1'b1, 4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b0, 0};
    tv[1] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 0};
    tv[2] = '{1'b0, 4'b1111, 1'b1, 4'b0001, 4'b0001, 1'b1, 0};
    tv[3] = '{1'b0, 4'b1110, 1'b1, 4'b0010, 4'b0010, 1'b1, 1};
    tv[4] = '{1'b0, 4'b1000, 1'b0, 4'b1000, 4'b0000, 1'b1, 3};
    tv[5] = '{1'b0, 4'b0100, 1'b1, 4'b0100, 4'b0100, 1'b1, 2};
    tv[6] = '{1'b0, 4'b1010, 1'b1, 4'b0010, 4'b0010, 1'b1, 1};
    do_reset();
`ifndef NOC_ARB_OUTREG_EN
    // All rows fit between two clock edges, so the arbiter stays in its reset state
    for (int i = 0; i < N; i++) bus.in_flit[i*W +: W] = 32'hC0DE_0000 + i;
    bus.in_last = '1;
    for (int r = 0; r < 7; r++) begin
      rst           = tv[r].r;
      bus.in_valid  = tv[r].v;
      bus.out_ready = tv[r].o;
      #1;
      chk($sformatf("vec%0d_grant", r), bus.grant, tv[r].g);
      chk($sformatf("vec%0d_in_ready", r), bus.in_ready, tv[r].rdy);
      chk($sformatf("vec%0d_out_valid", r), bus.out_valid, tv[r].ov);
      chk($sformatf("vec%0d_out_flit", r), bus.out_flit, tv[r].ov ? 32'hC0DE_0000 + tv[r].ch : 32'h0);
      chk($sformatf("vec%0d_busy", r), bus.busy, 1'b0);
    end
`endif
    do_reset();
    rr_load();
    drain("rr", 60);
    chk("rr_span", last_hs - first_hs + 1, 12);
    do_reset();
    rnd = 1'b1;
    rr_load();
    drain("rr_rand", 300);
    do_reset();
    put(1, 32'hAAAA_0001, 1'b0);
    put(1, 32'hAAAA_0002, 1'b0);
    put(1, 32'hAAAA_0003, 1'b1);
    drive();
    step();
    put(2, 32'hBBBB_0001, 1'b1);
    drive();
    #1;
    chk("nointlv_rdy2_b", bus.in_ready[2], 1'b0);
    chk("nointlv_grant_b", bus.grant, 4'b0010);
    step();
    #1;
    chk("nointlv_rdy2_c", bus.in_ready[2], 1'b0);
    chk("nointlv_grant_c", bus.grant, 4'b0010);
    step();
    #1;
    chk("nointlv_grant_d", bus.grant, 4'b0100);
    drain("nointlv", 30);
    do_reset();
    ordy = 1'b0;
    put(3, 32'hDEAD_BEEF, 1'b1);
    drive();
    for (int c = 0; c < 5; c++) begin
      #1;
`ifndef NOC_ARB_OUTREG_EN
      chk($sformatf("bp%0d_flit", c), bus.out_flit, 32'hDEAD_BEEF);
      chk($sformatf("bp%0d_grant", c), bus.grant, 4'b1000);
      chk($sformatf("bp%0d_valid", c), bus.out_valid, 1'b1);
      chk($sformatf("bp%0d_in_ready", c), bus.in_ready, 4'b0000);
`endif
      step();
    end
    ordy = 1'b1;
    drive();
    drain("bp", 30);
    do_reset();
    put(0, 32'h0000_00A0, 1'b0);
    put(0, 32'h0000_00A1, 1'b0);
    put(0, 32'h0000_00A2, 1'b1);
    put(1, 32'h0000_00B0, 1'b1);
    drive();
    step();
    mask = 4'b0001;
    drive();
    for (int c = 0; c < 2; c++) begin
      #1;
`ifndef NOC_ARB_OUTREG_EN
      chk($sformatf("bubble%0d_valid", c), bus.out_valid, 1'b0);
`endif
      chk($sformatf("bubble%0d_busy", c), bus.busy, 1'b1);
      chk($sformatf("bubble%0d_rdy1", c), bus.in_ready[1], 1'b0);
      step();
    end
    mask = '0;
    drive();
    drain("bubble", 30);
    do_reset();
    src[2].push_back({1'b0, 32'h2222_0000});
    src[2].push_back({1'b0, 32'h2222_0001});
    src[2].push_back({1'b1, 32'h2222_0002});
    exp_q.push_back({1'b0, 32'h2222_0000});
    drive();
    step();
    src[0].push_back({1'b1, 32'h0000_0C00});
    drive();
    #1;
    chk("rstmid_busy_pre", bus.busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("rstmid_busy", bus.busy, 1'b0);
    chk("rstmid_valid", bus.out_valid, 1'b0);
    chk("rstmid_grant", bus.grant, 4'b0000);
    chk("rstmid_in_ready", bus.in_ready, 4'b0000);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive();
    #1;
    chk("rstmid_grant_after", bus.grant, 4'b0001);
    exp_q.push_back({1'b1, 32'h0000_0C00});
    exp_q.push_back({1'b0, 32'h2222_0001});
    exp_q.push_back({1'b1, 32'h2222_0002});
    drain("rstmid", 30);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
